ucode_sequencer: RTL and testbench



---
 rtl/ucode_pkg.sv | 22 ++
 rtl/ucode_next_pc.sv | 37 +++
 rtl/ucode_sequencer.sv | 76 +++++++
 tb/tb_ucode_sequencer.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/ucode_pkg.sv
// ucode_pkg: widths, word-field positions, opcodes and FSM states shared by the microcode sequencer
package ucode_pkg;
  localparam int DATA_WIDTH = 46;
  localparam int SIZE       = 1024;
  localparam int ADDR_WIDTH = $clog2(SIZE);
  localparam int CTRL_WIDTH = DATA_WIDTH - 3 - ADDR_WIDTH;
  localparam int CTRL_LSB   = 0;
  localparam int CTRL_MSB   = CTRL_WIDTH - 1;
  localparam int IMM_LSB    = CTRL_WIDTH;
  localparam int IMM_MSB    = CTRL_WIDTH + ADDR_WIDTH - 1;
  localparam int OP_LSB     = IMM_MSB + 1;
  localparam int OP_MSB     = DATA_WIDTH - 1;
  localparam logic [2:0] OP_NEXT  = 3'b000;
  localparam logic [2:0] OP_JUMP  = 3'b001;
  localparam logic [2:0] OP_LDCNT = 3'b010;
  localparam logic [2:0] OP_LOOP  = 3'b011;
  localparam logic [2:0] OP_BRC   = 3'b100;
  localparam logic [2:0] OP_CALL  = 3'b101;
  localparam logic [2:0] OP_RET   = 3'b110;
  localparam logic [2:0] OP_HALT  = 3'b111;
  typedef enum logic {IDLE, RUN} state_e;
endpackage

// File: rtl/ucode_next_pc.sv
// ucode_next_pc: combinational op decode and next-address / next-counter select
// Ports: op_i/imm_i fields of the current word, pc_i, cnt_i, cond_i in;
//        next_pc_o, cnt_next_o, halt_o out.
// UCODE_CALL_EN adds ret_i / ret_next_o and decodes CALL/RET (otherwise they act as NEXT).
module ucode_next_pc
  import ucode_pkg::*;
(
  input  logic [2:0]            op_i,
  input  logic [ADDR_WIDTH-1:0] imm_i,
  input  logic [ADDR_WIDTH-1:0] pc_i,
  input  logic [ADDR_WIDTH-1:0] cnt_i,
  input  logic                  cond_i,
`ifdef UCODE_CALL_EN
  input  logic [ADDR_WIDTH-1:0] ret_i,
  output logic [ADDR_WIDTH-1:0] ret_next_o,
`endif
  output logic [ADDR_WIDTH-1:0] next_pc_o,
  output logic [ADDR_WIDTH-1:0] cnt_next_o,
  output logic                  halt_o
);
  logic [ADDR_WIDTH-1:0] inc;
  logic                  loop_taken;
  logic                  take_imm;
  always_comb begin
    inc        = (pc_i == ADDR_WIDTH'(SIZE - 1)) ? '0 : pc_i + 1'b1;
    loop_taken = (op_i == OP_LOOP) && (cnt_i != '0);
    take_imm   = (op_i == OP_JUMP) || loop_taken || ((op_i == OP_BRC) && cond_i);
    halt_o     = op_i == OP_HALT;
    cnt_next_o = (op_i == OP_LDCNT) ? imm_i : loop_taken ? cnt_i - 1'b1 : cnt_i;
`ifdef UCODE_CALL_EN
    ret_next_o = (op_i == OP_CALL) ? inc : ret_i;
    next_pc_o  = (take_imm || op_i == OP_CALL) ? imm_i : (op_i == OP_RET) ? ret_i : inc;
`else
    next_pc_o  = take_imm ? imm_i : inc;
`endif
  end
endmodule

// File: rtl/ucode_sequencer.sv
// ucode_sequencer: microcode sequencer issuing one control word per cycle from a registered-read store
// Ports: clk, reset_n (async, active-low); start_i/start_addr_i host start; stall_i, cond_i from datapath;
//        ucode_addr_o/ucode_data_i store read port; ctrl_valid_o, ctrl_o, pc_o, busy_o, done_o status.
// UCODE_CALL_EN enables CALL/RET with a one-level return register.
module ucode_sequencer
  import ucode_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] start_addr_i,
  input  logic                  stall_i,
  input  logic                  cond_i,
  output logic [ADDR_WIDTH-1:0] ucode_addr_o,
  input  logic [DATA_WIDTH-1:0] ucode_data_i,
  output logic                  ctrl_valid_o,
  output logic [CTRL_WIDTH-1:0] ctrl_o,
  output logic [ADDR_WIDTH-1:0] pc_o,
  output logic                  busy_o,
  output logic                  done_o
);
  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d, cnt_q, cnt_d, next_pc, cnt_next;
  logic                  halt;
  logic                  retire;
`ifdef UCODE_CALL_EN
  logic [ADDR_WIDTH-1:0] ret_q, ret_d, ret_next;
`endif
  ucode_next_pc u_next_pc (
    .op_i       (ucode_data_i[OP_MSB:OP_LSB]),
    .imm_i      (ucode_data_i[IMM_MSB:IMM_LSB]),
    .pc_i       (pc_q),
    .cnt_i      (cnt_q),
    .cond_i     (cond_i),
`ifdef UCODE_CALL_EN
    .ret_i      (ret_q),
    .ret_next_o (ret_next),
`endif
    .next_pc_o  (next_pc),
    .cnt_next_o (cnt_next),
    .halt_o     (halt)
  );
  // Stalls re-present pc to the store so the registered data (and ctrl_o) hold still.
  always_comb begin
    busy_o       = state_q == RUN;
    pc_o         = pc_q;
    retire       = busy_o && !halt && !stall_i;
    ctrl_valid_o = busy_o && !halt;
    done_o       = busy_o && halt;
    ctrl_o       = ctrl_valid_o ? ucode_data_i[CTRL_MSB:CTRL_LSB] : '0;
    ucode_addr_o = !ctrl_valid_o ? start_addr_i : stall_i ? pc_q : next_pc;
    state_d      = busy_o ? (halt ? IDLE : RUN) : (start_i ? RUN : IDLE);
    pc_d         = retire ? next_pc : (!busy_o && start_i) ? start_addr_i : pc_q;
    cnt_d        = retire ? cnt_next : cnt_q;
`ifdef UCODE_CALL_EN
    ret_d        = retire ? ret_next : ret_q;
`endif
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      pc_q    <= '0;
      cnt_q   <= '0;
`ifdef UCODE_CALL_EN
      ret_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
`ifdef UCODE_CALL_EN
      ret_q   <= ret_d;
`endif
    end
  end
endmodule

// File: tb/tb_ucode_sequencer.sv
// tb_ucode_sequencer: scoreboarded random/directed bench against an instruction-level reference model
module tb_ucode_sequencer;
  import ucode_pkg::*;
  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic [CTRL_WIDTH-1:0] ctrl;
    logic                  halt;
  } exp_t;
  logic                  clk = 0;
  logic                  reset_n = 1;
  logic                  start_i = 0;
  logic                  stall_i = 0;
  logic                  cond_i = 0;
  logic [ADDR_WIDTH-1:0] start_addr_i = '0;
  logic [ADDR_WIDTH-1:0] ucode_addr_o, pc_o;
  logic [DATA_WIDTH-1:0] ucode_data_i;
  logic                  ctrl_valid_o, busy_o, done_o;
  logic [CTRL_WIDTH-1:0] ctrl_o;
  logic [DATA_WIDTH-1:0] mem [SIZE];
  exp_t q[$];
  int   tests = 0, fails = 0, done_cnt = 0, m_cnt = 0, m_ret = 0;
  bit   running = 0;
  int   base, tries, imm, k;
  bit   ok, c;
  logic [2:0] op;

  always #5 clk = ~clk;
  always @(posedge clk) ucode_data_i <= mem[ucode_addr_o];

  ucode_sequencer dut (
    .clk(clk), .reset_n(reset_n), .start_i(start_i), .start_addr_i(start_addr_i),
    .stall_i(stall_i), .cond_i(cond_i), .ucode_addr_o(ucode_addr_o), .ucode_data_i(ucode_data_i),
    .ctrl_valid_o(ctrl_valid_o), .ctrl_o(ctrl_o), .pc_o(pc_o), .busy_o(busy_o), .done_o(done_o)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DATA_WIDTH-1:0] w(input logic [2:0] o, input int im);
    logic [ADDR_WIDTH-1:0] a;
    a = im[ADDR_WIDTH-1:0];
    return {o, a, CTRL_WIDTH'({$urandom, $urandom})};
  endfunction

  // Interprets the program word by word; commits the retire sequence only if it reaches HALT.
  task automatic model(input int b, input bit cnd, output bit good);
    exp_t lq[$];
    int pc, cnt, ret, nxt, im;
    logic [DATA_WIDTH-1:0] wd;
    logic [2:0] o;
    pc = b; cnt = m_cnt; ret = m_ret; good = 0;
    for (int s = 0; s < 300 && !good; s++) begin
      wd  = mem[pc];
      o   = wd[OP_MSB:OP_LSB];
      im  = int'(wd[IMM_MSB:IMM_LSB]);
      nxt = (pc + 1) % SIZE;
      lq.push_back(exp_t'{ADDR_WIDTH'(pc), wd[CTRL_MSB:CTRL_LSB], o == OP_HALT});
      if (o == OP_HALT) good = 1;
      else case (o)
        OP_JUMP:  pc = im;
        OP_LDCNT: begin cnt = im; pc = nxt; end
        OP_LOOP:  if (cnt != 0) begin cnt--; pc = im; end else pc = nxt;
        OP_BRC:   pc = cnd ? im : nxt;
`ifdef UCODE_CALL_EN
        OP_CALL:  begin ret = nxt; pc = im; end
        OP_RET:   pc = ret;
`endif
        default:  pc = nxt;
      endcase
    end
    if (good) begin
      foreach (lq[i]) q.push_back(lq[i]);
      m_cnt = cnt;
      m_ret = ret;
    end
  endtask

  always @(negedge clk) begin
    if (!reset_n) begin
      q.delete();
      running = 0;
    end else begin
      chk("busy", busy_o, running);
      if (running || ctrl_valid_o || done_o) begin
        if (q.size() == 0) chk("unexpected_issue", {ctrl_valid_o, done_o}, 0);
        else if (q[0].halt) begin
          chk("halt_pc", pc_o, q[0].pc);
          chk("halt_done", done_o, 1);
          chk("halt_valid", ctrl_valid_o, 0);
          chk("halt_addr", ucode_addr_o, start_addr_i);
          void'(q.pop_front());
        end else begin
          chk("issue_pc", pc_o, q[0].pc);
          chk("issue_valid", ctrl_valid_o, 1);
          chk("issue_done", done_o, 0);
          chk("issue_ctrl", ctrl_o, q[0].ctrl);
          if (stall_i) chk("stall_addr", ucode_addr_o, q[0].pc);
          else begin
            void'(q.pop_front());
            if (q.size() != 0) chk("next_addr", ucode_addr_o, q[0].pc);
          end
        end
      end
      if (done_o) done_cnt++;
      running = done_o ? 1'b0 : (running | start_i);
    end
  end

  task automatic go(input int b, input bit cnd, input int sp);
    int d0, n;
    @(posedge clk); #1;
    cond_i = cnd; start_i = 1; start_addr_i = ADDR_WIDTH'(b); d0 = done_cnt;
    @(posedge clk); #1;
    start_i = 0; n = 0;
    while (done_cnt == d0 && n < 3000) begin
      stall_i = $urandom_range(99) < sp;
      start_i = $urandom_range(9) == 0;
      start_addr_i = ADDR_WIDTH'($urandom);
      @(posedge clk); #1;
      n++;
    end
    stall_i = 0; start_i = 0;
    chk("run_completes", done_cnt != d0, 1);
    chk("queue_drained", q.size(), 0);
  endtask

  task automatic directed(input int b, input bit cnd, input int sp);
    bit good;
    model(b, cnd, good);
    if (good) go(b, cnd, sp);
  endtask

  initial begin
    foreach (mem[i]) mem[i] = w(OP_HALT, 0);
    #2 reset_n = 0;
    #10;
    chk("rst_valid", ctrl_valid_o, 0);
    chk("rst_ctrl", ctrl_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_pc", pc_o, 0);
    @(negedge clk); #1 reset_n = 1;
    mem[10] = w(OP_NEXT, 0); mem[11] = w(OP_NEXT, 0); mem[12] = w(OP_HALT, 0);
    directed(10, 0, 0);
    mem[0] = w(OP_LDCNT, 3); mem[1] = w(OP_NEXT, 0); mem[2] = w(OP_LOOP, 1); mem[3] = w(OP_HALT, 0);
    directed(0, 0, 0);
    directed(2, 0, 0);
    mem[5] = w(OP_JUMP, 20); mem[20] = w(OP_NEXT, 0); mem[21] = w(OP_HALT, 0);
    directed(5, 0, 70);
    mem[1023] = w(OP_BRC, 7); mem[0] = w(OP_HALT, 0); mem[7] = w(OP_HALT, 0);
    directed(1023, 0, 0);
    directed(1023, 1, 30);
    mem[4] = w(OP_CALL, 100); mem[100] = w(OP_RET, 0); mem[5] = w(OP_HALT, 0);
    directed(4, 0, 20);
    mem[200] = w(OP_LDCNT, 50); mem[201] = w(OP_NEXT, 0); mem[202] = w(OP_LOOP, 201); mem[203] = w(OP_HALT, 0);
    model(200, 0, ok);
    @(posedge clk); #1 start_i = 1; start_addr_i = 200;
    @(posedge clk); #1 start_i = 0;
    repeat (20) begin
      stall_i = $urandom_range(99) < 30;
      @(posedge clk); #1;
    end
    reset_n = 0;
    #1;
    chk("midrst_valid", ctrl_valid_o, 0);
    chk("midrst_ctrl", ctrl_o, 0);
    chk("midrst_busy", busy_o, 0);
    chk("midrst_done", done_o, 0);
    chk("midrst_pc", pc_o, 0);
    m_cnt = 0; m_ret = 0; stall_i = 0;
    @(negedge clk); #1 reset_n = 1;
    directed(10, 0, 25);
    repeat (40) begin
      base = $urandom_range(SIZE - 1);
      c = $urandom_range(1) == 1;
      tries = 0;
      ok = 0;
      while (!ok && tries < 100) begin
        for (int i = 0; i < 16; i++) begin
          k   = $urandom_range(9);
          op  = k < 3 ? OP_NEXT : 3'(k - 2);
          imm = op == OP_LDCNT ? $urandom_range(4) : (base + $urandom_range(15)) % SIZE;
          mem[(base + i) % SIZE] = w(op, imm);
        end
        model(base, c, ok);
        tries++;
      end
      if (ok) go(base, c, 30);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
